// File: rtl/sound_pkg.sv
// Shared types and constants for the note sequencer.
// Entry layout: [31:24] duration, [23:21] width, [20:16] volume, [15:0] period.
package sound_pkg;

   localparam int NOTE_W = 32;

   localparam int PERIOD_LSB = 0;
   localparam int VOLUME_LSB = 16;
   localparam int WIDTH_LSB = 21;
   localparam int DUR_LSB = 24;

   localparam logic [15:0] DEFAULT_PERIOD = 16'd14205;
   localparam logic [2:0] DEFAULT_WIDTH = 3'd3;

   typedef struct packed {
      logic [7:0] duration;
      logic [2:0] width;
      logic [4:0] volume;
      logic [15:0] period;
   } note_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      PLAY,
      GAP,
      FINISH
   } seq_state_t;

endpackage

// File: rtl/sound_sequencer_tick_prescaler.sv
// Modulo-TICK_DIV cycle counter; tick pulses for one cycle at the wrap.
// A synchronous clear restarts the count at zero.
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input logic clk,
   input logic rst,
   input logic clr,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sound_sequencer.sv
// Steps through a CPU-written note table, presenting each note's settings
// for its duration followed by a one-tick silent gap.
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int TICK_DIV = 50000,
   parameter int AW = 4
) (
   input logic clk,
   input logic rst,
   input logic wr_en,
   input logic [AW-1:0] wr_addr,
   input logic [31:0] wr_data,
   input logic start,
   input logic stop,
   input logic loop,
   output logic [15:0] period,
   output logic [4:0] volume,
   output logic [2:0] width,
   output logic gate,
   output logic busy,
   output logic done,
   output logic [AW-1:0] cur_idx
);

   localparam logic [AW-1:0] LAST_IDX = '1;

   note_t table_q [2**AW];
   note_t entry;

   seq_state_t state, state_d;
   logic [AW-1:0] idx_d;
   logic [4:0] vol_q;
   logic [7:0] dur_q;
   logic [7:0] tick_cnt;
   logic load;
   logic end_go;
   logic tick;
   logic clr;

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_presc (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .tick(tick)
   );

   always_ff @(posedge clk) begin
      if (wr_en) begin
         table_q[wr_addr] <= note_t'(wr_data);
      end
   end

   assign entry = table_q[cur_idx];
   assign clr = (state != PLAY) && (state != GAP);

   always_comb begin
      state_d = state;
      idx_d = cur_idx;
      load = 1'b0;
      end_go = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !stop) begin
               state_d = FETCH;
               idx_d = '0;
            end
         end
         FETCH: begin
            if (entry.duration == 8'd0) begin
               end_go = 1'b1;
            end else begin
               load = 1'b1;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (tick && (tick_cnt + 8'd1 == dur_q)) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (tick) begin
               if (cur_idx == LAST_IDX) begin
                  end_go = 1'b1;
               end else begin
                  idx_d = cur_idx + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // An empty table with loop set must still finish rather than spin.
      if (end_go) begin
         if (loop && (cur_idx != '0)) begin
            idx_d = '0;
            state_d = FETCH;
         end else begin
            state_d = FINISH;
         end
      end
      if (stop && (state != IDLE)) begin
         state_d = IDLE;
         idx_d = cur_idx;
         load = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cur_idx <= '0;
         period <= DEFAULT_PERIOD;
         width <= DEFAULT_WIDTH;
         vol_q <= '0;
         dur_q <= '0;
         tick_cnt <= '0;
      end else begin
         state <= state_d;
         cur_idx <= idx_d;
         if (load) begin
            period <= entry.period;
            width <= entry.width;
            vol_q <= entry.volume;
            dur_q <= entry.duration;
            tick_cnt <= '0;
         end else if ((state == PLAY) && tick) begin
            tick_cnt <= tick_cnt + 8'd1;
         end
      end
   end

   assign gate = (state == PLAY);
   assign volume = gate ? vol_q : 5'd0;
   assign busy = (state != IDLE);
   assign done = (state == FINISH);

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed checks of the note sequencer with a short tick and a 4-entry table.
// Inputs change 1 time unit after a rising edge and outputs are sampled there.
module tb_sound_sequencer;

   localparam int TD = 4;
   localparam int AW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic loop = 1'b0;
   logic [15:0] period;
   logic [4:0] volume;
   logic [2:0] width;
   logic gate;
   logic busy;
   logic done;
   logic [AW-1:0] cur_idx;

   int n_run = 0;
   int n_fail = 0;

   sound_sequencer #(
      .TICK_DIV(TD),
      .AW(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .start(start),
      .stop(stop),
      .loop(loop),
      .period(period),
      .volume(volume),
      .width(width),
      .gate(gate),
      .busy(busy),
      .done(done),
      .cur_idx(cur_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   function automatic logic [31:0] note(input int dur, input int w, input int v, input int p);
      return {8'(dur), 3'(w), 5'(v), 16'(p)};
   endfunction

   int cnt;
   int dn;
   int idxq[$];
   int perq[$];
   logic pg;
   bit seen;

   initial begin
      #12;
      chk("rst_period", period, 14205);
      chk("rst_volume", volume, 0);
      chk("rst_width", width, 3);
      chk("rst_flags", {gate, busy, done}, 0);
      chk("rst_idx", cur_idx, 0);
      rst = 1'b0;
      step();

      // single note then end marker
      wr(0, note(2, 1, 8, 100));
      wr(1, 32'h0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t2_fetch", {gate, busy}, 2'b01);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (gate && period == 16'd100 && volume == 5'd8 && width == 3'd1) cnt++;
      end
      chk("t2_play_cycles", cnt, 8);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (!gate && volume == 5'd0 && period == 16'd100 && busy) cnt++;
      end
      chk("t2_gap_cycles", cnt, 4);
      step();
      chk("t2_fetch_marker", {done, busy, 30'(cur_idx)}, {2'b01, 30'd1});
      step();
      chk("t2_done", {done, busy}, 2'b11);
      step();
      chk("t2_idle", {done, busy, gate}, 3'b000);
      chk("t2_idx_hold", cur_idx, 1);

      // four notes, no loop
      for (int i = 0; i < 4; i++) wr(i, note(1, 2, i + 1, 200 + i));
      start = 1'b1;
      step();
      start = 1'b0;
      idxq = {};
      perq = {};
      dn = 0;
      pg = 1'b0;
      for (int k = 0; k < 60 && busy; k++) begin
         if (idxq.size() == 0 || idxq[$] != int'(cur_idx)) idxq.push_back(int'(cur_idx));
         if (gate && !pg) perq.push_back(int'(period));
         if (done) dn++;
         pg = gate;
         step();
      end
      chk("t3_idx_count", idxq.size(), 4);
      for (int i = 0; i < 4 && i < idxq.size(); i++) chk("t3_idx_seq", idxq[i], i);
      chk("t3_period_rise", perq.size() == 4 ? perq[3] : -1, 203);
      chk("t3_done_once", dn, 1);
      chk("t3_final", {busy, 30'(cur_idx)}, {1'b0, 30'd3});

      // same table, looping; a start while busy must be ignored
      loop = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      idxq = {};
      dn = 0;
      for (int k = 1; k <= 40; k++) begin
         if (idxq.size() == 0 || idxq[$] != int'(cur_idx)) idxq.push_back(int'(cur_idx));
         if (done) dn++;
         start = (k == 10);
         step();
      end
      start = 1'b0;
      chk("t4_idx_count", idxq.size(), 5);
      chk("t4_wrap", idxq.size() == 5 ? idxq[4] : -1, 0);
      chk("t4_no_done", dn, 0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (gate) seen = 1'b1;
         else step();
      end
      chk("t4_gate_seen", seen, 1);
      chk("t4_period_idx0", period, 200);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t4_stop", {gate, busy, done, 5'(volume)}, 0);
      chk("t4_stop_period_hold", period, 200);
      step();
      chk("t4_stop_no_done", {done, busy}, 0);

      // empty table with loop
      wr(0, 32'h0);
      start = 1'b1;
      step();
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 3 && !seen; k++) begin
         if (done) seen = 1'b1;
         else step();
      end
      chk("t5_done", seen, 1);
      step();
      chk("t5_idle", busy, 0);
      loop = 1'b0;

      // start and stop together in IDLE
      wr(0, note(3, 5, 17, 321));
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      chk("t6_stop_wins", busy, 0);

      // async reset mid-note
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("t6_playing", {gate, 16'(period), 5'(volume), 3'(width)}, {1'b1, 16'd321, 5'd17, 3'd5});
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_period", period, 14205);
      chk("t6_async_flags", {gate, busy, done, 5'(volume), 3'(width)}, {8'h0, 3'd3});
      rst = 1'b0;
      step();
      chk("t6_after_rst", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
